uart_plus: RTL

//  Next-generation UART core: baud generator, RX and TX framing engines, RX and TX FIFOs.

---
 rtl/uart_plus_pkg.sv | 29 ++
 rtl/fifo.sv | 51 +++++
 rtl/uart_plus_rx.sv | 123 ++++++++++++
 rtl/uart_plus.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_plus_pkg.sv
// Shared constants, frame-engine state encoding and parity helper for uart_plus.
package uart_plus_pkg;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } uart_state_e;

  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // data is zero-extended by callers, which leaves the XOR reduction unchanged
  function automatic logic calc_parity(input logic [1:0] mode, input logic [15:0] data);
    logic p;
    case (mode)
      PAR_EVEN: p = ^data;
      PAR_ODD:  p = ~(^data);
      default:  p = 1'b0;
    endcase
    return p;
  endfunction
endpackage

// File: rtl/fifo.sv
// Synchronous FIFO; full-write ignored unless a read happens in the same cycle.
module fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic         rd,
  input  logic [W-1:0] w_data,
  output logic [W-1:0] r_data,
  output logic         empty,
  output logic         full
);
  localparam int DEPTH = 2 ** AW;

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          wr_ok_s;
  logic          rd_ok_s;

  assign empty   = (count_r == (AW+1)'(0));
  assign full    = (count_r == (AW+1)'(DEPTH));
  assign rd_ok_s = rd & ~empty;
  assign wr_ok_s = wr & (~full | rd);
  assign r_data  = mem_r[rd_ptr_r];

  // storage array
  always_ff @(posedge clk) begin
    if (wr_ok_s) mem_r[wr_ptr_r] <= w_data;
  end

  // pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else begin
      if (wr_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (rd_ok_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/uart_plus_rx.sv
// RX engine: 2-flop synchroniser, oversampled framing FSM, parity/framing error capture.
// With UART_PLUS_LOOPBACK_EN defined an idle indication is exported.
module uart_plus_rx import uart_plus_pkg::*; #(
  parameter int DBIT = 8,
  parameter int OVS  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic            rx_in,
  input  logic [1:0]      par_mode,
  output logic            push,
  output logic [DBIT+1:0] word
`ifdef UART_PLUS_LOOPBACK_EN
  , output logic          idle
`endif
);
  localparam int CW = $clog2(OVS);
  localparam logic [CW-1:0] HALF     = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] LAST     = CW'(OVS - 1);
  localparam logic [3:0]    BIT_LAST = 4'(DBIT - 1);

  logic [1:0]      sync_r;
  logic            rx_s;
  uart_state_e     state_r;
  logic [CW-1:0]   cnt_r;
  logic [3:0]      bit_r;
  logic [DBIT-1:0] data_r;
  logic [1:0]      mode_r;
  logic            perr_r;
  logic            push_r;
  logic [DBIT+1:0] word_r;

  assign rx_s = sync_r[1];
  assign push = push_r;
  assign word = word_r;
`ifdef UART_PLUS_LOOPBACK_EN
  assign idle = (state_r == ST_IDLE);
`endif

  // line synchroniser, idles high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_r <= 2'b11;
    else       sync_r <= {sync_r[0], rx_in};
  end

  // framing FSM; word is pushed after the first stop-bit sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= CW'(0);
      bit_r   <= 4'd0;
      data_r  <= DBIT'(0);
      mode_r  <= PAR_NONE;
      perr_r  <= 1'b0;
      push_r  <= 1'b0;
      word_r  <= (DBIT+2)'(0);
    end else begin
      push_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!rx_s) begin
            state_r <= ST_START;
            cnt_r   <= CW'(0);
          end
        end
        ST_START: begin
          if (tick) begin
            if (cnt_r == HALF) begin
              cnt_r <= CW'(0);
              if (rx_s) begin
                state_r <= ST_IDLE;
              end else begin
                state_r <= ST_DATA;
                bit_r   <= 4'd0;
                mode_r  <= par_mode;
                perr_r  <= 1'b0;
              end
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (cnt_r == LAST) begin
              cnt_r  <= CW'(0);
              data_r <= {rx_s, data_r[DBIT-1:1]};
              if (bit_r == BIT_LAST) state_r <= par_enabled(mode_r) ? ST_PAR : ST_STOP;
              else                   bit_r   <= bit_r + 4'd1;
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
        end
        ST_PAR: begin
          if (tick) begin
            if (cnt_r == LAST) begin
              cnt_r   <= CW'(0);
              perr_r  <= (rx_s != calc_parity(mode_r, 16'(data_r)));
              state_r <= ST_STOP;
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (cnt_r == LAST) begin
              cnt_r   <= CW'(0);
              push_r  <= 1'b1;
              word_r  <= {~rx_s, perr_r, data_r};
              state_r <= ST_IDLE;
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/uart_plus.sv
// uart_plus top: baud tick, TX engine, RX engine and RX/TX FIFOs with error flags.
// Optional internal loopback when UART_PLUS_LOOPBACK_EN is defined.
module uart_plus import uart_plus_pkg::*; #(
  parameter int DBIT   = 8,
  parameter int OVS    = 16,
  parameter int FIFO_W = 2,
  parameter int DVSR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic [1:0]        par_mode,
  input  logic              stop2,
  input  logic              wr_uart,
  input  logic [DBIT-1:0]   w_data,
  input  logic              rd_uart,
  output logic [DBIT-1:0]   r_data,
  output logic              r_perr,
  output logic              r_ferr,
  output logic              rx_empty,
  output logic              tx_full,
  output logic              tx_empty,
  output logic              tx_busy,
  output logic              overrun,
  input  logic              clr_err,
  input  logic              rx,
  output logic              tx
`ifdef UART_PLUS_LOOPBACK_EN
  , input  logic            loopback
`endif
);
  localparam int TCW = $clog2(2 * OVS);
  localparam logic [TCW-1:0] T_LAST   = TCW'(OVS - 1);
  localparam logic [TCW-1:0] T_LAST2  = TCW'(2 * OVS - 1);
  localparam logic [3:0]     BIT_LAST = 4'(DBIT - 1);

  logic [DVSR_W-1:0] tick_cnt_r;
  logic              tick_s;
  uart_state_e       tx_state_r;
  logic [TCW-1:0]    tx_cnt_r;
  logic [3:0]        tx_bit_r;
  logic [DBIT-1:0]   tx_data_r;
  logic              tx_pen_r;
  logic              tx_par_r;
  logic              tx_stop2_r;
  logic              tx_line_r;
  logic              tx_busy_r;
  logic              tx_stop_done_s;
  logic              tx_load_s;
  logic [DBIT-1:0]   tx_head_s;
  logic              rx_src_s;
  logic              rx_push_s;
  logic [DBIT+1:0]   rx_word_s;
  logic [DBIT+1:0]   rx_head_s;
  logic              rx_full_s;
  logic              overrun_r;

  assign tick_s  = (tick_cnt_r == dvsr);
  assign tx_busy = tx_busy_r;
  assign overrun = overrun_r;
  assign r_data  = rx_head_s[DBIT-1:0];
  assign r_perr  = rx_head_s[DBIT];
  assign r_ferr  = rx_head_s[DBIT+1];

  // baud tick: one pulse every dvsr+1 cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       tick_cnt_r <= DVSR_W'(0);
    else if (tick_s) tick_cnt_r <= DVSR_W'(0);
    else             tick_cnt_r <= tick_cnt_r + DVSR_W'(1);
  end

  // a new frame loads from idle, or straight out of the last stop tick so frames abut
  always_comb begin
    if ((tx_state_r == ST_STOP) && tick_s)
      tx_stop_done_s = (tx_cnt_r == (tx_stop2_r ? T_LAST2 : T_LAST));
    else
      tx_stop_done_s = 1'b0;
    tx_load_s = ~tx_empty & ((tx_state_r == ST_IDLE) | tx_stop_done_s);
  end

  // TX framing FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_r <= ST_IDLE;
      tx_cnt_r   <= TCW'(0);
      tx_bit_r   <= 4'd0;
      tx_data_r  <= DBIT'(0);
      tx_pen_r   <= 1'b0;
      tx_par_r   <= 1'b0;
      tx_stop2_r <= 1'b0;
      tx_line_r  <= 1'b1;
      tx_busy_r  <= 1'b0;
    end else if (tx_load_s) begin
      tx_state_r <= ST_START;
      tx_cnt_r   <= TCW'(0);
      tx_data_r  <= tx_head_s;
      tx_pen_r   <= par_enabled(par_mode);
      tx_par_r   <= calc_parity(par_mode, 16'(tx_head_s));
      tx_stop2_r <= stop2;
      tx_line_r  <= 1'b0;
      tx_busy_r  <= 1'b1;
    end else begin
      case (tx_state_r)
        ST_IDLE: begin
          tx_line_r <= 1'b1;
          tx_busy_r <= 1'b0;
        end
        ST_START: begin
          if (tick_s) begin
            if (tx_cnt_r == T_LAST) begin
              tx_cnt_r   <= TCW'(0);
              tx_bit_r   <= 4'd0;
              tx_line_r  <= tx_data_r[0];
              tx_state_r <= ST_DATA;
            end else begin
              tx_cnt_r <= tx_cnt_r + TCW'(1);
            end
          end
        end
        ST_DATA: begin
          if (tick_s) begin
            if (tx_cnt_r == T_LAST) begin
              tx_cnt_r <= TCW'(0);
              if (tx_bit_r == BIT_LAST) begin
                tx_state_r <= tx_pen_r ? ST_PAR : ST_STOP;
                tx_line_r  <= tx_pen_r ? tx_par_r : 1'b1;
              end else begin
                tx_bit_r  <= tx_bit_r + 4'd1;
                tx_line_r <= tx_data_r[1];
                tx_data_r <= {1'b0, tx_data_r[DBIT-1:1]};
              end
            end else begin
              tx_cnt_r <= tx_cnt_r + TCW'(1);
            end
          end
        end
        ST_PAR: begin
          if (tick_s) begin
            if (tx_cnt_r == T_LAST) begin
              tx_cnt_r   <= TCW'(0);
              tx_line_r  <= 1'b1;
              tx_state_r <= ST_STOP;
            end else begin
              tx_cnt_r <= tx_cnt_r + TCW'(1);
            end
          end
        end
        ST_STOP: begin
          if (tx_stop_done_s) begin
            tx_cnt_r   <= TCW'(0);
            tx_busy_r  <= 1'b0;
            tx_state_r <= ST_IDLE;
          end else if (tick_s) begin
            tx_cnt_r <= tx_cnt_r + TCW'(1);
          end
        end
        default: tx_state_r <= ST_IDLE;
      endcase
    end
  end

`ifdef UART_PLUS_LOOPBACK_EN
  logic lb_r;
  logic rx_idle_s;

  // loopback select only moves while both engines are idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        lb_r <= 1'b0;
    else if ((tx_state_r == ST_IDLE) && rx_idle_s)    lb_r <= loopback;
    else                                              lb_r <= lb_r;
  end

  assign rx_src_s = lb_r ? tx_line_r : rx;
  assign tx       = tx_line_r | lb_r;
`else
  assign rx_src_s = rx;
  assign tx       = tx_line_r;
`endif

  uart_plus_rx #(.DBIT(DBIT), .OVS(OVS)) u_rx (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick_s),
    .rx_in    (rx_src_s),
    .par_mode (par_mode),
    .push     (rx_push_s),
    .word     (rx_word_s)
`ifdef UART_PLUS_LOOPBACK_EN
    , .idle   (rx_idle_s)
`endif
  );

  fifo #(.W(DBIT), .AW(FIFO_W)) u_tx_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr_uart),
    .rd     (tx_load_s),
    .w_data (w_data),
    .r_data (tx_head_s),
    .empty  (tx_empty),
    .full   (tx_full)
  );

  fifo #(.W(DBIT + 2), .AW(FIFO_W)) u_rx_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr     (rx_push_s),
    .rd     (rd_uart),
    .w_data (rx_word_s),
    .r_data (rx_head_s),
    .empty  (rx_empty),
    .full   (rx_full_s)
  );

  // sticky overrun; a drop in the same cycle as clr_err wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  overrun_r <= 1'b0;
    else if (rx_push_s & rx_full_s & ~rd_uart)  overrun_r <= 1'b1;
    else if (clr_err)                           overrun_r <= 1'b0;
    else                                        overrun_r <= overrun_r;
  end
endmodule
